line_delay_taps: RTL and testbench

//  Multi-tap programmable line delay for neighbourhood filters (3x3/5x5 windows) in the

---
 rtl/line_delay_taps.sv | 115 +++++++++++
 tb/tb_line_delay_taps.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_delay_taps.sv
// line_delay_taps: cascaded run-time-length line delays for neighbourhood filters.
// Tap k presents the input delayed by (k+1)*size_l enabled samples. All taps share one
// write/read pointer. RAM contents survive reset, so tap_valid masks stale words.
module line_delay_taps #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_TAPS     = 2,
    parameter int ADDRESS_SIZE = 12
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           restart,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic [15:0]                    size,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] taps_out,
    output logic [NUM_TAPS-1:0]            tap_valid,
    output logic                           size_error
);

    localparam int DEPTH = 2 ** ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE:0]   SIZE_ONE = {{ADDRESS_SIZE{1'b0}}, 1'b1};
    localparam logic [ADDRESS_SIZE:0]   DEPTH_L  = {1'b1, {ADDRESS_SIZE{1'b0}}};
    localparam logic [ADDRESS_SIZE-1:0] PTR_ONE  = {{(ADDRESS_SIZE-1){1'b0}}, 1'b1};
    localparam logic [16:0]             DEPTH_W  = 17'(DEPTH);
    localparam logic [23:0]             FILL_ONE = 24'd1;

    logic [DATA_WIDTH-1:0]   ram [NUM_TAPS][DEPTH];
    logic [ADDRESS_SIZE-1:0] ptr;
    logic [ADDRESS_SIZE:0]   size_l;
    logic [ADDRESS_SIZE:0]   size_clamped;
    logic                    size_clamp_err;
    logic [23:0]             fill;
    logic [23:0]             fill_max;
    logic [23:0]             size_l24;
    logic [23:0]             thr [NUM_TAPS];
    logic                    reset_seen;
    logic                    latch_size;
    logic                    clear;
    logic                    advance;
    logic                    ptr_at_end;

    // Size is only captured on the first reset edge and on restart, so a
    // size change mid-line cannot disturb the running delay.
    assign latch_size = (!reset_n && !reset_seen) || (reset_n && restart);
    assign clear      = !reset_n || restart;
    assign advance    = !clear && enable;
    assign ptr_at_end = ({1'b0, ptr} == (size_l - SIZE_ONE));
    assign size_l24   = 24'(size_l);
    assign fill_max   = 24'(NUM_TAPS) * size_l24;

    // Clamp the requested size into 1..DEPTH and flag when clamping happened.
    always_comb begin
        size_clamped   = size[ADDRESS_SIZE:0];
        size_clamp_err = 1'b0;
        if (size == 16'd0) begin
            size_clamped   = SIZE_ONE;
            size_clamp_err = 1'b1;
        end else if ({1'b0, size} > DEPTH_W) begin
            size_clamped   = DEPTH_L;
            size_clamp_err = 1'b1;
        end
    end

    // Fill thresholds: tap k becomes valid once (k+1)*size_l samples are stored.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            thr[k] = 24'(k + 1) * size_l24;
        end
    end

    // Tracks that reset was already asserted last edge, so only its first edge latches size.
    always_ff @(posedge clk) begin
        reset_seen <= !reset_n;
    end

    // Latched line length and its out-of-range flag.
    always_ff @(posedge clk) begin
        if (latch_size) begin
            size_l     <= size_clamped;
            size_error <= size_clamp_err;
        end
    end

    // Line RAMs: read-before-write, each tap feeds the next at the same address.
    always_ff @(posedge clk) begin
        if (advance) begin
            ram[0][ptr] <= data_in;
            for (int k = 1; k < NUM_TAPS; k++) begin
                ram[k][ptr] <= ram[k-1][ptr];
            end
        end
    end

    // Pointer, fill counter, registered tap outputs and sticky valid flags.
    always_ff @(posedge clk) begin
        if (clear) begin
            ptr       <= '0;
            fill      <= '0;
            taps_out  <= '0;
            tap_valid <= '0;
        end else if (enable) begin
            ptr <= ptr_at_end ? '0 : ptr + PTR_ONE;
            if (fill < fill_max) begin
                fill <= fill + FILL_ONE;
            end
            for (int k = 0; k < NUM_TAPS; k++) begin
                taps_out[k*DATA_WIDTH +: DATA_WIDTH] <= ram[k][ptr];
                if (fill >= thr[k]) begin
                    tap_valid[k] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_delay_taps.sv
// Bench for line_delay_taps: a hand-written vector table for the basic ramp, then
// model-driven sequences whose predictions go through a scoreboard queue.
module tb_line_delay_taps;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        restart;
    logic [7:0]  data_in;
    logic [15:0] size;
    logic [15:0] taps_out;
    logic [1:0]  tap_valid;
    logic        size_error;

    line_delay_taps #(.DATA_WIDTH(8), .NUM_TAPS(2), .ADDRESS_SIZE(12)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .restart    (restart),
        .data_in    (data_in),
        .size       (size),
        .taps_out   (taps_out),
        .tap_valid  (tap_valid),
        .size_error (size_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] taps;
        logic [1:0]  mask;
        logic [1:0]  valid;
        logic        serr;
    } exp_t;

    typedef struct {
        bit         rn;
        bit         rs;
        bit         en;
        logic [7:0] d;
        int         sz;
        exp_t       e;
    } vec_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    string tname    = "init";

    // reference model state
    int         s_m      = 1;
    bit         serr_m   = 1'b0;
    bit         in_rst_m = 1'b0;
    logic [7:0] hist[$];
    logic [15:0] otaps   = '0;
    logic [1:0]  oknown  = 2'b00;
    logic [1:0]  ovalid  = 2'b00;

    function automatic exp_t mk(input logic [15:0] t, input logic [1:0] m,
                                input logic [1:0] v, input logic se);
        exp_t e;
        e.taps = t; e.mask = m; e.valid = v; e.serr = se;
        return e;
    endfunction

    function automatic vec_t row(input bit rn, input bit rs, input bit en, input logic [7:0] d,
                                 input int sz, input exp_t e);
        vec_t v;
        v.rn = rn; v.rs = rs; v.en = en; v.d = d; v.sz = sz; v.e = e;
        return v;
    endfunction

    task automatic model_latch(input int sz);
        if (sz == 0) begin
            s_m = 1; serr_m = 1'b1;
        end else if (sz > 4096) begin
            s_m = 4096; serr_m = 1'b1;
        end else begin
            s_m = sz; serr_m = 1'b0;
        end
    endtask

    task automatic model_step(input bit rn, input bit rs, input bit en, input logic [7:0] d,
                              input int sz);
        int n;
        int thr;
        if (!rn || rs) begin
            if ((!rn && !in_rst_m) || (rn && rs)) model_latch(sz);
            in_rst_m = !rn;
            hist.delete();
            otaps  = '0;
            oknown = 2'b11;
            ovalid = 2'b00;
        end else begin
            in_rst_m = 1'b0;
            if (en) begin
                n = hist.size();
                for (int k = 0; k < 2; k++) begin
                    thr = (k + 1) * s_m;
                    if (n >= thr) begin
                        otaps[k*8 +: 8] = hist[n - thr];
                        ovalid[k] = 1'b1;
                        oknown[k] = 1'b1;
                    end else begin
                        oknown[k] = 1'b0;
                    end
                end
                hist.push_back(d);
            end
        end
    endtask

    task automatic check_out();
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard_empty", tname);
            return;
        end
        e = sb.pop_front();
        if (tap_valid !== e.valid) begin
            n_fail++;
            $display("FAIL %s tap_valid: got %b expected %b", tname, tap_valid, e.valid);
        end
        n_checks++;
        if (size_error !== e.serr) begin
            n_fail++;
            $display("FAIL %s size_error: got %b expected %b", tname, size_error, e.serr);
        end
        for (int k = 0; k < 2; k++) begin
            if (e.mask[k]) begin
                n_checks++;
                if (taps_out[k*8 +: 8] !== e.taps[k*8 +: 8]) begin
                    n_fail++;
                    $display("FAIL %s tap%0d: got %0d expected %0d", tname, k,
                             taps_out[k*8 +: 8], e.taps[k*8 +: 8]);
                end
            end
        end
    endtask

    task automatic drive(input bit rn, input bit rs, input bit en, input logic [7:0] d,
                         input int sz);
        reset_n = rn;
        restart = rs;
        enable  = en;
        data_in = d;
        size    = sz[15:0];
        model_step(rn, rs, en, d, sz);
    endtask

    task automatic cycle(input bit rn, input bit rs, input bit en, input logic [7:0] d,
                         input int sz);
        drive(rn, rs, en, d, sz);
        sb.push_back(mk(otaps, oknown, ovalid, serr_m));
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic cycle_tab(input vec_t v);
        drive(v.rn, v.rs, v.en, v.d, v.sz);
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic ramp(input int count, input int sz);
        for (int i = 0; i < count; i++) cycle(1'b1, 1'b0, 1'b1, 8'(i + 1), sz);
    endtask

    task automatic rand_run(input int count, input int sz);
        for (int i = 0; i < count; i++) cycle(1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)), sz);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tab[13];

    initial begin
        reset_n = 1'b0; restart = 1'b0; enable = 1'b0; data_in = '0; size = 16'd4;

        // T1: size 4 ramp, expectations written out by hand
        tab[0]  = row(0, 0, 0, 8'd0,  4, mk(16'h0000, 2'b11, 2'b00, 1'b0));
        tab[1]  = row(0, 0, 1, 8'd0,  4, mk(16'h0000, 2'b11, 2'b00, 1'b0));
        tab[2]  = row(1, 0, 1, 8'd1,  4, mk(16'h0000, 2'b00, 2'b00, 1'b0));
        tab[3]  = row(1, 0, 1, 8'd2,  4, mk(16'h0000, 2'b00, 2'b00, 1'b0));
        tab[4]  = row(1, 0, 1, 8'd3,  4, mk(16'h0000, 2'b00, 2'b00, 1'b0));
        tab[5]  = row(1, 0, 1, 8'd4,  4, mk(16'h0000, 2'b00, 2'b00, 1'b0));
        tab[6]  = row(1, 0, 1, 8'd5,  4, mk(16'h0001, 2'b01, 2'b01, 1'b0));
        tab[7]  = row(1, 0, 1, 8'd6,  4, mk(16'h0002, 2'b01, 2'b01, 1'b0));
        tab[8]  = row(1, 0, 1, 8'd7,  4, mk(16'h0003, 2'b01, 2'b01, 1'b0));
        tab[9]  = row(1, 0, 1, 8'd8,  4, mk(16'h0004, 2'b01, 2'b01, 1'b0));
        tab[10] = row(1, 0, 1, 8'd9,  4, mk(16'h0105, 2'b11, 2'b11, 1'b0));
        tab[11] = row(1, 0, 1, 8'd10, 4, mk(16'h0206, 2'b11, 2'b11, 1'b0));
        tab[12] = row(1, 0, 0, 8'd99, 4, mk(16'h0206, 2'b11, 2'b11, 1'b0));
        tname = "T1_table";
        for (int i = 0; i < 13; i++) cycle_tab(tab[i]);

        // T2: enable low every other cycle, idle data must never be stored
        tname = "T2_gapped";
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 4);
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) cycle(1'b1, 1'b0, 1'b1, 8'(i / 2 + 1), 4);
            else            cycle(1'b1, 1'b0, 1'b0, 8'($urandom_range(100, 255)), 4);
        end

        // T3: size change without restart is ignored; restart drops its enable
        tname = "T3_resize";
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 4);
        ramp(10, 4);
        ramp(8, 3);
        cycle(1'b1, 1'b1, 1'b1, 8'd77, 3);
        ramp(8, 3);
        cycle(1'b1, 1'b0, 1'b0, 8'd0, 3);

        // T4: out-of-range sizes are clamped and flagged
        tname = "T4_size0";
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 0);
        ramp(6, 0);
        tname = "T4_size5000";
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 5000);
        rand_run(4100, 5000);
        tname = "T4_size1";
        cycle(1'b1, 1'b1, 1'b0, 8'd0, 1);
        ramp(4, 1);

        // T5: full-depth line, tap1 continuous across pointer wrap
        tname = "T5_depth";
        cycle(1'b1, 1'b1, 1'b0, 8'd0, 4096);
        rand_run(3 * 4096, 4096);

        // T6: reset mid-stream, refill must not flag stale RAM as valid
        tname = "T6_midreset";
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 4);
        ramp(6, 4);
        cycle(1'b0, 1'b0, 1'b1, 8'd50, 4);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 8'(i + 20), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
